// File: rtl/timer_array.sv
// N_CH-channel countdown timer bank with per-channel sticky, maskable interrupts.
// Optional shared prescaler enabled by defining TIMER_ARRAY_PRESCALE_EN.
module timer_array #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            IRQ,
  output logic [N_CH-1:0] IRQ_vec
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic        tick;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        presc_sel;
  logic [31:0] presc_rd;
  logic [31:0] rd_word [8];
  logic        unused_addr;

  assign ch_sel      = Addr[6:4];
  assign reg_sel     = Addr[3:2];
  assign presc_sel   = Addr[7] && (Addr[6:2] == 5'd0);
  assign unused_addr = ^Addr[31:8];

`ifdef TIMER_ARRAY_PRESCALE_EN
  logic [15:0] presc_q;
  logic [15:0] pcnt_q;

  assign tick     = (pcnt_q == presc_q);
  assign presc_rd = {16'd0, presc_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (WE && presc_sel) begin
      presc_q <= Din[15:0];
      pcnt_q  <= '0;
    end else if (tick) begin
      pcnt_q  <= '0;
    end else begin
      pcnt_q  <= pcnt_q + 16'd1;
    end
  end
`else
  assign tick     = 1'b1;
  assign presc_rd = 32'd0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [3:0]       ctrl_q, ctrl_d;
      logic [CNT_W-1:0] preset_q;
      logic [CNT_W-1:0] count_q, count_d;
      logic             pend_q, pend_d;
      logic [1:0]       state_q, state_d;
      logic             irq_q;
      logic             sel;

      assign sel = !Addr[7] && (ch_sel == 3'(gi));

      always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        pend_d  = pend_q;
        state_d = state_q;
        // Clear is applied first so an INT in the same cycle re-sets pending.
        if (WE && sel && reg_sel == 2'd3 && Din[0]) pend_d = 1'b0;
        case (state_q)
          S_IDLE: if (ctrl_q[0]) state_d = S_LOAD;
          S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
          end
          S_CNT: begin
            if (!ctrl_q[0]) begin
              state_d = S_IDLE;
            end else if (tick) begin
              if (count_q <= CNT_W'(1)) begin
                count_d = '0;
                state_d = S_INT;
              end else begin
                count_d = count_q - CNT_W'(1);
              end
            end
          end
          default: begin
            pend_d = 1'b1;
            if (ctrl_q[2:1] == 2'b01) begin
              state_d = S_LOAD;
            end else begin
              ctrl_d[0] = 1'b0;
              state_d   = S_IDLE;
            end
          end
        endcase
        // A bus write to CTRL overrides the auto-clear of EN.
        if (WE && sel && reg_sel == 2'd0) ctrl_d = Din[3:0];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ctrl_q   <= '0;
          preset_q <= '0;
          count_q  <= '0;
          pend_q   <= 1'b0;
          state_q  <= S_IDLE;
          irq_q    <= 1'b0;
        end else begin
          ctrl_q  <= ctrl_d;
          count_q <= count_d;
          pend_q  <= pend_d;
          state_q <= state_d;
          irq_q   <= pend_q & ctrl_q[3];
          if (WE && sel && reg_sel == 2'd1) preset_q <= Din[CNT_W-1:0];
        end
      end

      assign IRQ_vec[gi] = irq_q;
      assign rd_word[gi] = (reg_sel == 2'd0) ? 32'(ctrl_q)   :
                           (reg_sel == 2'd1) ? 32'(preset_q) :
                           (reg_sel == 2'd2) ? 32'(count_q)  : 32'(pend_q);
    end

    for (gi = N_CH; gi < 8; gi++) begin : g_empty
      assign rd_word[gi] = 32'd0;
    end
  endgenerate

  always_comb begin
    Dout = rd_word[ch_sel];
    if (Addr[7]) Dout = presc_sel ? presc_rd : 32'd0;
  end

  assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: timing of count/pending/IRQ, masking, clear races and reset.
module tb_timer_array;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic [3:0]  IRQ_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timer_array #(.N_CH(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .IRQ_vec(IRQ_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    Addr = 30'(a >> 2);
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    $display("WR addr=0x%02h data=0x%0h", a, d);
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    Addr = 30'(a >> 2);
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] m;
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    #12 reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk_rd("rst_ctrl0", 8'h00, 0);
    chk_rd("rst_preset0", 8'h04, 0);
    chk_rd("rst_count0", 8'h08, 0);
    chk_rd("rst_status0", 8'h0C, 0);
    chk_rd("rst_presc", 8'h80, 0);
    check("rst_irq", IRQ, 0);
    check("rst_irqvec", IRQ_vec, 0);

    // Ignored writes / unmapped reads
    wr(8'h08, 7);
    chk_rd("count_ro", 8'h08, 0);
    wr(8'h40, 5);
    chk_rd("ch4_zero", 8'h40, 0);
    chk_rd("addr84_zero", 8'h84, 0);

    // 1: one-shot P=5 with IM
    wr(8'h04, 5);
    wr(8'h00, 9);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 7) chk_rd($sformatf("t1_count_k%0d", k), 8'h08, 7 - k);
      if (k == 7) chk_rd("t1_status_early", 8'h0C, 0);
      if (k == 8) begin
        chk_rd("t1_status_set", 8'h0C, 1);
        check("t1_irq_low", IRQ, 0);
      end
      if (k == 9) check("t1_irq_high", IRQ, 1);
    end
    chk_rd("t1_ctrl", 8'h00, 8);
    chk_rd("t1_status", 8'h0C, 1);
    check("t1_irqvec", IRQ_vec, 4'b0001);

    // 2: clear, then auto-reload P=3
    wr(8'h0C, 1);
    chk_rd("t2_status_clr", 8'h0C, 0);
    check("t2_irq_still", IRQ, 1);
    step(1);
    check("t2_irq_low", IRQ, 0);
    wr(8'h04, 3);
    wr(8'h00, 32'hB);
    step(2);  chk_rd("t2_count_n2", 8'h08, 3);
    step(3);  chk_rd("t2_status_n5", 8'h0C, 0);
    step(1);  chk_rd("t2_status_n6", 8'h0C, 1);
    step(1);  chk_rd("t2_count_n7", 8'h08, 3);
    wr(8'h0C, 1);
    chk_rd("t2_status_n8", 8'h0C, 0);
    step(2);  chk_rd("t2_status_n10", 8'h0C, 0);
    step(1);  chk_rd("t2_status_n11", 8'h0C, 1);
    step(1);  chk_rd("t2_count_n12", 8'h08, 3);
    wr(8'h00, 0);
    wr(8'h0C, 1);
    step(2);
    check("t2_irq_off", IRQ, 0);
    chk_rd("t2_ctrl_off", 8'h00, 0);
    chk_rd("t2_count_frozen", 8'h08, 2);

    // 3: four channels P=2,4,6,8 enabled on consecutive cycles
    for (int g = 0; g < 4; g++) wr(8'(16 * g + 4), 32'(2 + 2 * g));
    for (int g = 0; g < 4; g++) wr(8'(16 * g), 9);
    for (int n = 4; n <= 16; n++) begin
      @(negedge clk);
      m = '0;
      for (int g = 0; g < 4; g++) if (n >= 6 + 3 * g) m[g] = 1'b1;
      check($sformatf("t3_irqvec_n%0d", n), IRQ_vec, m);
    end
    for (int g = 0; g < 3; g++) wr(8'(16 * g + 12), 1);
    step(1);
    check("t3_irqvec_ch3", IRQ_vec, 4'b1000);
    check("t3_irq_held", IRQ, 1);
    wr(8'h3C, 1);
    step(1);
    check("t3_irq_cleared", IRQ, 0);

    // 4: masked pending, late IM, clear-vs-set race (ch1), write-vs-INT race (ch2)
    wr(8'h14, 1);
    wr(8'h10, 1);
    step(4);  chk_rd("t4_status_masked", 8'h1C, 1);
    step(2);  check("t4_irq_masked", IRQ, 0);
    wr(8'h10, 8);
    check("t4_irq_pre_im", IRQ, 0);
    step(1);  check("t4_irq_im", IRQ, 1);
    wr(8'h1C, 1);
    wr(8'h10, 9);
    step(3);
    wr(8'h1C, 1);
    chk_rd("t4_set_wins", 8'h1C, 1);
    chk_rd("t4_ctrl1", 8'h10, 8);
    step(1);  check("t4_irq_race", IRQ, 1);
    wr(8'h24, 1);
    wr(8'h20, 1);
    step(3);
    wr(8'h20, 1);
    chk_rd("t4_write_wins", 8'h20, 1);
    wr(8'h20, 0);

    // 5: asynchronous reset mid-count
    wr(8'h04, 100);
    wr(8'h00, 9);
    step(10);
    chk_rd("t5_count_pre", 8'h08, 92);
    check("t5_irq_pre", IRQ, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_irq_async", IRQ, 0);
    check("t5_irqvec_async", IRQ_vec, 0);
    chk_rd("t5_count_async", 8'h08, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_rd("t5_ctrl_post", 8'h00, 0);
    step(2);
    chk_rd("t5_count_post", 8'h08, 0);
    chk_rd("t5_status1_post", 8'h1C, 0);

    // 6: prescaler
`ifdef TIMER_ARRAY_PRESCALE_EN
    wr(8'h80, 3);
    wr(8'h04, 2);
    wr(8'h00, 1);
    chk_rd("t6_presc", 8'h80, 3);
    step(5);  chk_rd("t6_count_n5", 8'h08, 2);
    step(1);  chk_rd("t6_count_n6", 8'h08, 1);
    step(3);  chk_rd("t6_count_n9", 8'h08, 1);
    step(1);  chk_rd("t6_count_n10", 8'h08, 0);
`else
    wr(8'h80, 32'hFFFF);
    chk_rd("t6_presc_absent", 8'h80, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
